sp_ram_sim_model: RTL and testbench



---
 rtl/sp_ram_sim_model.sv | 56 +++++
 tb/tb_sp_ram_sim_model.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sp_ram_sim_model.sv
// Behavioural single-port RAM: per-bit write mask, registered read port.
// Optional build macro SP_RAM_WRITE_THROUGH_EN: on a write, DO also loads the merged word.
module sp_ram_sim_model #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  CE,
  input  logic                  RDWEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic [DATA_WIDTH-1:0] BW,
  output logic [DATA_WIDTH-1:0] DO
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // rst_n deliberately leaves the array alone; contents start at zero.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] merged;
  logic                  ctrl_ok;

  assign merged = (mem[A] & ~BW) | (DI & BW);

`ifndef SYNTHESIS
  // An unknown address or opcode must not corrupt the array.
  assign ctrl_ok = !($isunknown(A) || $isunknown(RDWEN));

  always @(posedge CLK) begin
    if (rst_n === 1'b1 && CE === 1'b1 && ($isunknown(A) || $isunknown(RDWEN)))
      $display("WARNING %m: X/Z on A or RDWEN with CE=1 at time %0t", $time);
  end
`else
  assign ctrl_ok = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (rst_n && CE && RDWEN && ctrl_ok)
      mem[A] <= merged;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      DO <= '0;
    end else if (CE && ctrl_ok) begin
      if (!RDWEN)
        DO <= mem[A];
`ifdef SP_RAM_WRITE_THROUGH_EN
      else
        DO <= merged;
`endif
    end
  end

endmodule

// File: tb/tb_sp_ram_sim_model.sv
// Directed bench for sp_ram_sim_model (ADDR_WIDTH=4, DATA_WIDTH=8).
// Expected DO after a write follows SP_RAM_WRITE_THROUGH_EN when it is defined.
module tb_sp_ram_sim_model;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          CE;
  logic          RDWEN;
  logic [AW-1:0] A;
  logic [DW-1:0] DI;
  logic [DW-1:0] BW;
  logic [DW-1:0] DO;

  int n_assert = 0;
  int n_fail   = 0;

  sp_ram_sim_model #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .CE   (CE),
    .RDWEN(RDWEN),
    .A    (A),
    .DI   (DI),
    .BW   (BW),
    .DO   (DO)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    CE = 1'b1; RDWEN = 1'b1; A = a; DI = d; BW = m;
    tick();
    CE = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    CE = 1'b1; RDWEN = 1'b0; A = a; DI = 8'h00; BW = 8'h00;
    tick();
    CE = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; CE = 1'b0; RDWEN = 1'b0; A = '0; DI = '0; BW = '0;
    #23;
    chk("reset_do", DO, 8'h00);
    rst_n = 1'b1;
    tick();

    wr(4'd3, 8'h5A, 8'hFF);
`ifdef SP_RAM_WRITE_THROUGH_EN
    chk("full_write_do", DO, 8'h5A);
`else
    chk("full_write_do", DO, 8'h00);
`endif
    rd(4'd3);
    chk("full_write_rd", DO, 8'h5A);
    rd(4'd5);
    chk("init_zero_rd", DO, 8'h00);
    rd(4'd3);

    wr(4'd3, 8'hFF, 8'h0F);
`ifdef SP_RAM_WRITE_THROUGH_EN
    chk("masked_write_do", DO, 8'h5F);
`else
    chk("masked_write_do", DO, 8'h5A);
`endif
    rd(4'd3);
    chk("masked_write_rd", DO, 8'h5F);

    for (int i = 0; i < 5; i++) begin
      CE = 1'b0; RDWEN = i[0]; A = AW'(i * 3 + 1); DI = 8'hC0 + 8'(i); BW = 8'hFF;
      tick();
      chk($sformatf("idle_hold_%0d", i), DO, 8'h5F);
    end

    wr(4'd7, 8'h11, 8'hFF);
`ifdef SP_RAM_WRITE_THROUGH_EN
    chk("wr_then_rd_do", DO, 8'h11);
`else
    chk("wr_then_rd_do", DO, 8'h5F);
`endif
    rd(4'd7);
    chk("wr_then_rd_rd", DO, 8'h11);

    wr(4'd2, 8'hA5, 8'hFF);
    rd(4'd2);
    chk("pre_reset_rd", DO, 8'hA5);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_do", DO, 8'h00);
    CE = 1'b1; RDWEN = 1'b1; A = 4'd2; DI = 8'h00; BW = 8'hFF;
    tick();
    chk("reset_hold_do", DO, 8'h00);
    CE = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    rd(4'd2);
    chk("post_reset_rd", DO, 8'hA5);

    wr(4'd15, 8'hC3, 8'hFF);
    wr(4'd0,  8'h3C, 8'hFF);
    rd(4'd15);
    chk("last_addr_rd", DO, 8'hC3);
    rd(4'd0);
    chk("addr0_rd", DO, 8'h3C);

    wr(4'd3, 8'h00, 8'h00);
    rd(4'd3);
    chk("bw_zero_rd", DO, 8'h5F);

    CE = 1'b1; RDWEN = 1'b0; A = 'x; DI = 8'hEE; BW = 8'hFF;
    tick();
    CE = 1'b0; A = '0;
    rd(4'd3);
    chk("x_addr_m3", DO, 8'h5F);
    rd(4'd7);
    chk("x_addr_m7", DO, 8'h11);
    rd(4'd15);
    chk("x_addr_m15", DO, 8'hC3);
    rd(4'd0);
    chk("x_addr_m0", DO, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
